// File: rtl/popcnt_detect_arb.sv
// Round-robin arbiter feeding a bit-serial population counter with a two-digit match detector.
// Optional macro HIT_STAT_EN builds a saturating counter of accepted matching responses.
module popcnt_detect_arb #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DIGIT1 = 0,
   parameter int unsigned DIGIT2 = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*9-1:0]       word,
   output logic [NREQ-1:0]         grant,
   output logic                    busy,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [3:0]              rsp_ones,
   output logic                    rsp_hit,
   output logic [15:0]             hit_cnt
);

   localparam int unsigned IW = $clog2(NREQ);

   typedef enum logic [1:0] {StIdle, StCount, StResp} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] id_q, id_d;
   logic [8:0]    shreg_q, shreg_d;
   logic [3:0]    acc_q, acc_d;
   logic [3:0]    bit_q, bit_d;

   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] cand;
   logic [8:0]    win_word;
   logic          hit;

   // Search starts one past the last granted requester and wraps.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         cand = IW'((32'(last_q) + off) % NREQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      win_word = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (win_idx == IW'(i)) win_word = word[9*i +: 9];
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      shreg_d = shreg_q;
      acc_d   = acc_q;
      bit_d   = bit_q;
      grant   = '0;
      unique case (state_q)
         StIdle: begin
            // Grant is gated by rst_n so it drops the instant reset asserts.
            if (win_found && rst_n) begin
               grant   = NREQ'(1) << win_idx;
               last_d  = win_idx;
               id_d    = win_idx;
               shreg_d = win_word;
               acc_d   = '0;
               bit_d   = '0;
               state_d = StCount;
            end
         end
         StCount: begin
            acc_d   = acc_q + {3'b000, shreg_q[0]};
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 4'd1;
            if (bit_q == 4'd8) state_d = StResp;
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         last_q  <= IW'(NREQ - 1);
         id_q    <= '0;
         shreg_q <= '0;
         acc_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         shreg_q <= shreg_d;
         acc_q   <= acc_d;
         bit_q   <= bit_d;
      end
   end

   assign hit       = (acc_q == 4'(DIGIT1)) || (acc_q == 4'(DIGIT2));
   assign busy      = (state_q != StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_id    = rsp_valid ? id_q : '0;
   assign rsp_ones  = rsp_valid ? acc_q : '0;
   assign rsp_hit   = rsp_valid & hit;

`ifdef HIT_STAT_EN
   logic [15:0] hit_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q <= '0;
      end else if (rsp_valid && rsp_ready && hit && (hit_cnt_q != 16'hFFFF)) begin
         hit_cnt_q <= hit_cnt_q + 16'd1;
      end
   end

   assign hit_cnt = hit_cnt_q;
`else
   assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_popcnt_detect_arb.sv
// Directed bench for popcnt_detect_arb: reset, round-robin order, latency, backpressure,
// mid-operation reset and hit statistics.
module tb_popcnt_detect_arb;

   localparam int unsigned NREQ = 4;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*9-1:0] word;
   logic [NREQ-1:0]   grant;
   logic              busy;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [3:0]        rsp_ones;
   logic              rsp_hit;
   logic [15:0]       hit_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0] words   [NREQ] = '{9'h07F, 9'h000, 9'h1FF, 9'h155};
   int         ex_ones [NREQ] = '{7, 0, 9, 5};
   int         ex_hit  [NREQ] = '{1, 1, 0, 0};
   int         ex_hcnt;

   popcnt_detect_arb #(.NREQ(NREQ), .DIGIT1(0), .DIGIT2(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .word      (word),
      .grant     (grant),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_ones  (rsp_ones),
      .rsp_hit   (rsp_hit),
      .hit_cnt   (hit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_words();
      for (int i = 0; i < int'(NREQ); i++) word[9*i +: 9] = words[i];
   endtask

   initial begin
`ifdef HIT_STAT_EN
      ex_hcnt = 3;
`else
      ex_hcnt = 0;
`endif
      rst_n     = 1'b0;
      req       = 4'b1111;
      rsp_ready = 1'b1;
      load_words();
      #3;
      check_eq("rst_grant", 32'(grant), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_valid", 32'(rsp_valid), 32'h0);
      check_eq("rst_id", 32'(rsp_id), 32'h0);
      check_eq("rst_ones", 32'(rsp_ones), 32'h0);
      check_eq("rst_hit", 32'(rsp_hit), 32'h0);
      check_eq("rst_hitcnt", 32'(hit_cnt), 32'h0);
      req = '0;
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Round robin with all requests held: 0,1,2,3,0 every 11 cycles.
      req = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         check_eq("rr_grant", 32'(grant), 32'(1) << (k % 4));
         check_eq("rr_idle_busy", 32'(busy), 32'h0);
         tick();
         word = {NREQ{9'h0AA}};
         check_eq("cnt_grant", 32'(grant), 32'h0);
         check_eq("cnt_busy", 32'(busy), 32'h1);
         for (int t = 0; t < 8; t++) tick();
         check_eq("early_valid", 32'(rsp_valid), 32'h0);
         tick();
         check_eq("rsp_valid", 32'(rsp_valid), 32'h1);
         check_eq("rsp_id", 32'(rsp_id), 32'(k % 4));
         check_eq("rsp_ones", 32'(rsp_ones), 32'(ex_ones[k % 4]));
         check_eq("rsp_hit", 32'(rsp_hit), 32'(ex_hit[k % 4]));
         check_eq("rsp_grant", 32'(grant), 32'h0);
         load_words();
         tick();
         check_eq("post_valid", 32'(rsp_valid), 32'h0);
      end
      req = '0;
      #1;
      check_eq("hit_cnt", 32'(hit_cnt), 32'(ex_hcnt));

      // Backpressure: hold the response 5 extra cycles with all requests pending.
      rsp_ready = 1'b0;
      req       = 4'b0100;
      #1;
      check_eq("bp_grant", 32'(grant), 32'h4);
      tick();
      req = 4'b1111;
      for (int t = 0; t < 9; t++) tick();
      for (int t = 0; t < 6; t++) begin
         check_eq("bp_valid", 32'(rsp_valid), 32'h1);
         check_eq("bp_id", 32'(rsp_id), 32'h2);
         check_eq("bp_ones", 32'(rsp_ones), 32'h9);
         check_eq("bp_hit", 32'(rsp_hit), 32'h0);
         check_eq("bp_grant", 32'(grant), 32'h0);
         check_eq("bp_busy", 32'(busy), 32'h1);
         if (t < 5) tick();
      end
      req       = '0;
      rsp_ready = 1'b1;
      tick();
      check_eq("bp_done_valid", 32'(rsp_valid), 32'h0);
      check_eq("bp_done_busy", 32'(busy), 32'h0);
      check_eq("bp_hit_cnt", 32'(hit_cnt), 32'(ex_hcnt));

      // Reset in cycle 4 of COUNT discards the operation.
      req = 4'b0010;
      #1;
      check_eq("mr_grant", 32'(grant), 32'h2);
      tick();
      req = '0;
      for (int t = 0; t < 3; t++) tick();
      check_eq("mr_busy_pre", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check_eq("mr_busy", 32'(busy), 32'h0);
      check_eq("mr_valid", 32'(rsp_valid), 32'h0);
      check_eq("mr_grant0", 32'(grant), 32'h0);
      check_eq("mr_ones", 32'(rsp_ones), 32'h0);
      check_eq("mr_hitcnt", 32'(hit_cnt), 32'h0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 12; t++) begin
         tick();
         check_eq("mr_no_rsp", 32'(rsp_valid), 32'h0);
      end
      req = 4'b0011;
      #1;
      check_eq("mr_first_grant", 32'(grant), 32'h1);
      tick();
      req = '0;
      for (int t = 0; t < 9; t++) tick();
      check_eq("mr_rsp_valid", 32'(rsp_valid), 32'h1);
      check_eq("mr_rsp_id", 32'(rsp_id), 32'h0);
      check_eq("mr_rsp_ones", 32'(rsp_ones), 32'h7);
      check_eq("mr_rsp_hit", 32'(rsp_hit), 32'h1);
      tick();
      check_eq("mr_end_busy", 32'(busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
